video_timing: RTL and testbench

Parametrised raster timing generator, successor to the fixed 1024x768 XVGA generator. It produces pixel/line counters, sync, blank, and frame/line markers for any mode set by parameters. It also adds a pixel-clock enable and a configurable sync/blank delay that matches downstream pixel pipeline latency. It sits at the head of the display path and drives the pixel generators and the VGA output stage.

---
 rtl/video_pkg.sv | 77 +++++++
 rtl/sync_delay.sv | 35 +++
 rtl/video_timing.sv | 120 ++++++++++++
 tb/tb_video_timing.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared raster timing definitions: standard mode constants, the totals helper
// and the {hsync,vsync,blank} bundle type.
package video_pkg;

    localparam int unsigned XGA_H_ACTIVE  = 1024;
    localparam int unsigned XGA_H_FP      = 24;
    localparam int unsigned XGA_H_SYNC    = 136;
    localparam int unsigned XGA_H_BP      = 160;
    localparam int unsigned XGA_V_ACTIVE  = 768;
    localparam int unsigned XGA_V_FP      = 3;
    localparam int unsigned XGA_V_SYNC    = 6;
    localparam int unsigned XGA_V_BP      = 29;

    localparam int unsigned VGA_H_ACTIVE  = 640;
    localparam int unsigned VGA_H_FP      = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BP      = 48;
    localparam int unsigned VGA_V_ACTIVE  = 480;
    localparam int unsigned VGA_V_FP      = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BP      = 33;

    localparam int unsigned SVGA_H_ACTIVE = 800;
    localparam int unsigned SVGA_H_FP     = 40;
    localparam int unsigned SVGA_H_SYNC   = 128;
    localparam int unsigned SVGA_H_BP     = 88;
    localparam int unsigned SVGA_V_ACTIVE = 600;
    localparam int unsigned SVGA_V_FP     = 1;
    localparam int unsigned SVGA_V_SYNC   = 4;
    localparam int unsigned SVGA_V_BP     = 23;

    localparam int unsigned MODE_FIELD_W  = 12;

    typedef enum logic [1:0] {
        MODE_VGA,
        MODE_SVGA,
        MODE_XGA
    } mode_e;

    typedef struct packed {
        logic [MODE_FIELD_W-1:0] h_active;
        logic [MODE_FIELD_W-1:0] h_fp;
        logic [MODE_FIELD_W-1:0] h_sync;
        logic [MODE_FIELD_W-1:0] h_bp;
        logic [MODE_FIELD_W-1:0] v_active;
        logic [MODE_FIELD_W-1:0] v_fp;
        logic [MODE_FIELD_W-1:0] v_sync;
        logic [MODE_FIELD_W-1:0] v_bp;
    } mode_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
    } sync_t;

    // Line or frame length from its four segments.
    function automatic int unsigned total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // Timing set for a named standard mode, for callers selecting modes at run time.
    function automatic mode_t mode_timing(input mode_e m);
        mode_t r;
        case (m)
            MODE_VGA:  r = '{12'(VGA_H_ACTIVE), 12'(VGA_H_FP), 12'(VGA_H_SYNC), 12'(VGA_H_BP),
                             12'(VGA_V_ACTIVE), 12'(VGA_V_FP), 12'(VGA_V_SYNC), 12'(VGA_V_BP)};
            MODE_SVGA: r = '{12'(SVGA_H_ACTIVE), 12'(SVGA_H_FP), 12'(SVGA_H_SYNC), 12'(SVGA_H_BP),
                             12'(SVGA_V_ACTIVE), 12'(SVGA_V_FP), 12'(SVGA_V_SYNC), 12'(SVGA_V_BP)};
            default:   r = '{12'(XGA_H_ACTIVE), 12'(XGA_H_FP), 12'(XGA_H_SYNC), 12'(XGA_H_BP),
                             12'(XGA_V_ACTIVE), 12'(XGA_V_FP), 12'(XGA_V_SYNC), 12'(XGA_V_BP)};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Ce-gated shift register that delays the sync bundle to match downstream
// pixel pipeline latency; depth 0 is a straight wire.
module sync_delay
    import video_pkg::*;
#(
    parameter int unsigned DEPTH = 0,
    parameter sync_t       IDLE  = '1
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  ce,
    input  sync_t bundle,
    output sync_t delayed
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ok;
        assign unused_ok = ^{clk, reset, ce};
        assign delayed   = bundle;
    end else begin : g_pipe
        sync_t stage [DEPTH];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < int'(DEPTH); i++) stage[i] <= IDLE;
            end else if (ce) begin
                stage[0] <= bundle;
                for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
            end
        end

        assign delayed = stage[DEPTH-1];
    end

endmodule

// File: rtl/video_timing.sv
// Parametrised raster timing generator: pixel/line counters, sync, blank,
// line/frame markers and a pipeline-matched delayed copy of the syncs.
module video_timing
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = XGA_H_ACTIVE,
    parameter int unsigned H_FP       = XGA_H_FP,
    parameter int unsigned H_SYNC     = XGA_H_SYNC,
    parameter int unsigned H_BP       = XGA_H_BP,
    parameter int unsigned V_ACTIVE   = XGA_V_ACTIVE,
    parameter int unsigned V_FP       = XGA_V_FP,
    parameter int unsigned V_SYNC     = XGA_V_SYNC,
    parameter int unsigned V_BP       = XGA_V_BP,
    parameter bit          HSYNC_POL  = 1'b0,
    parameter bit          VSYNC_POL  = 1'b0,
    parameter int unsigned H_W        = 11,
    parameter int unsigned V_W        = 10,
    parameter int unsigned PIPE_DELAY = 0,
    parameter int unsigned FRAME_W    = 8
) (
    input  logic               vclock,
    input  logic               reset,
    input  logic               ce,
    output logic [H_W-1:0]     hcount,
    output logic [V_W-1:0]     vcount,
    output logic               hsync,
    output logic               vsync,
    output logic               blank,
    output logic               hsync_d,
    output logic               vsync_d,
    output logic               blank_d,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int unsigned H_TOTAL  = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL  = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam sync_t       IDLE     = '{hsync: ~HSYNC_POL, vsync: ~VSYNC_POL, blank: 1'b1};

    if (H_W == 0 || V_W == 0 || FRAME_W == 0) begin : g_bad_width
        $error("video_timing: zero counter width");
    end
    if (longint'(H_TOTAL) > (64'd1 << H_W)) begin : g_bad_h
        $error("video_timing: H_TOTAL does not fit in H_W bits");
    end
    if (longint'(V_TOTAL) > (64'd1 << V_W)) begin : g_bad_v
        $error("video_timing: V_TOTAL does not fit in V_W bits");
    end
    if (PIPE_DELAY > 15) begin : g_bad_delay
        $error("video_timing: PIPE_DELAY above 15");
    end

    // Sync/blank decoded from a raster position.
    function automatic sync_t decode(input logic [H_W-1:0] h, input logic [V_W-1:0] v);
        sync_t s;
        s.blank = (32'(h) >= H_ACTIVE) || (32'(v) >= V_ACTIVE);
        s.hsync = ((32'(h) >= HS_START) && (32'(h) < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        s.vsync = ((32'(v) >= VS_START) && (32'(v) < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        return s;
    endfunction

    logic           wrap_h;
    logic           wrap_v;
    logic [H_W-1:0] h_next;
    logic [V_W-1:0] v_next;
    sync_t          cur;
    sync_t          dly;

    always_comb begin
        wrap_h = (32'(hcount) == H_TOTAL - 1);
        wrap_v = (32'(vcount) == V_TOTAL - 1);
        h_next = wrap_h ? '0 : hcount + H_W'(1);
        v_next = vcount;
        if (wrap_h) v_next = wrap_v ? '0 : vcount + V_W'(1);
    end

    // Outputs are decoded from the next counter values so they land aligned with them.
    always_ff @(posedge vclock) begin
        if (reset) begin
            hcount      <= '0;
            vcount      <= '0;
            frame_count <= '0;
            cur         <= decode('0, '0);
            line_start  <= 1'b1;
            frame_start <= 1'b1;
        end else if (ce) begin
            hcount      <= h_next;
            vcount      <= v_next;
            cur         <= decode(h_next, v_next);
            line_start  <= (h_next == '0);
            frame_start <= (h_next == '0) && (v_next == '0);
            if (wrap_h && wrap_v) frame_count <= frame_count + FRAME_W'(1);
        end
    end

    assign hsync = cur.hsync;
    assign vsync = cur.vsync;
    assign blank = cur.blank;

    sync_delay #(
        .DEPTH (PIPE_DELAY),
        .IDLE  (IDLE)
    ) u_sync_delay (
        .clk     (vclock),
        .reset   (reset),
        .ce      (ce),
        .bundle  (cur),
        .delayed (dly)
    );

    assign hsync_d = dly.hsync;
    assign vsync_d = dly.vsync;
    assign blank_d = dly.blank;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: a small custom mode (delayed, active-high hsync, 2-bit
// frame counter) and the default XGA mode, both checked against a raster model.
module tb_video_timing;

    localparam int S_HA = 16, S_HF = 2, S_HS = 3, S_HB = 4;   // 25 pixels per line
    localparam int S_VA = 6,  S_VF = 1, S_VS = 2, S_VB = 2;   // 11 lines per frame
    localparam int S_D  = 3,  S_FW = 2;
    localparam bit S_HP = 1'b1, S_VP = 1'b0;

    logic vclock = 1'b0;
    logic reset  = 1'b1;
    logic ce     = 1'b0;

    logic [4:0] s_hcount;
    logic [3:0] s_vcount;
    logic [1:0] s_frame_count;
    logic s_hsync, s_vsync, s_blank, s_hsync_d, s_vsync_d, s_blank_d, s_line_start, s_frame_start;

    logic [10:0] x_hcount;
    logic [9:0]  x_vcount;
    logic [7:0]  x_frame_count;
    logic x_hsync, x_vsync, x_blank, x_hsync_d, x_vsync_d, x_blank_d, x_line_start, x_frame_start;

    video_timing #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .HSYNC_POL(S_HP), .VSYNC_POL(S_VP), .H_W(5), .V_W(4),
        .PIPE_DELAY(S_D), .FRAME_W(S_FW)
    ) u_small (
        .vclock(vclock), .reset(reset), .ce(ce),
        .hcount(s_hcount), .vcount(s_vcount),
        .hsync(s_hsync), .vsync(s_vsync), .blank(s_blank),
        .hsync_d(s_hsync_d), .vsync_d(s_vsync_d), .blank_d(s_blank_d),
        .line_start(s_line_start), .frame_start(s_frame_start), .frame_count(s_frame_count)
    );

    video_timing u_xga (
        .vclock(vclock), .reset(reset), .ce(ce),
        .hcount(x_hcount), .vcount(x_vcount),
        .hsync(x_hsync), .vsync(x_vsync), .blank(x_blank),
        .hsync_d(x_hsync_d), .vsync_d(x_vsync_d), .blank_d(x_blank_d),
        .line_start(x_line_start), .frame_start(x_frame_start), .frame_count(x_frame_count)
    );

    always #5 vclock = ~vclock;

    typedef struct {
        int h, v, fc;
        bit hs, vs, bl, hsd, vsd, bld, ls, fs;
    } exp_t;

    int     n_cmp  = 0;
    int     n_fail = 0;
    longint t      = 0;      // ce-cycles since the last reset
    bit     chk_en = 1'b0;

    function automatic void chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", nm, act, exp, t);
        end
    endfunction

    // {hsync, vsync, blank} for pixel (h, v) straight from the window rules.
    function automatic logic [2:0] raw(input int h, input int v, input int ha, input int hf,
                                       input int hs, input int va, input int vf, input int vs,
                                       input bit hp, input bit vp);
        bit in_h = (h >= ha + hf) && (h < ha + hf + hs);
        bit in_v = (v >= va + vf) && (v < va + vf + vs);
        return {in_h ? hp : ~hp, in_v ? vp : ~vp, (h >= ha) || (v >= va)};
    endfunction

    // Expected outputs after t ce-cycles of free-running raster since reset.
    function automatic exp_t model(input longint tt, input int ha, input int hf, input int hs,
                                   input int hb, input int va, input int vf, input int vs,
                                   input int vb, input bit hp, input bit vp, input int d,
                                   input int fw);
        exp_t   e;
        longint ht = longint'(ha + hf + hs + hb);
        longint vt = longint'(va + vf + vs + vb);
        longint td;
        e.h  = int'(tt % ht);
        e.v  = int'((tt / ht) % vt);
        e.fc = int'((tt / (ht * vt)) % (64'd1 << fw));
        {e.hs, e.vs, e.bl} = raw(e.h, e.v, ha, hf, hs, va, vf, vs, hp, vp);
        e.ls = (e.h == 0);
        e.fs = (e.h == 0) && (e.v == 0);
        if (tt < longint'(d)) begin
            {e.hsd, e.vsd, e.bld} = {~hp, ~vp, 1'b1};
        end else begin
            td = tt - longint'(d);
            {e.hsd, e.vsd, e.bld} = raw(int'(td % ht), int'((td / ht) % vt),
                                        ha, hf, hs, va, vf, vs, hp, vp);
        end
        return e;
    endfunction

    // Every-cycle comparison of both instances against the model.
    always @(negedge vclock) begin
        exp_t e;
        if (chk_en) begin
            e = model(t, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, S_HP, S_VP, S_D, S_FW);
            chk("s_hcount", s_hcount, e.h);           chk("s_vcount", s_vcount, e.v);
            chk("s_hsync", s_hsync, e.hs);            chk("s_vsync", s_vsync, e.vs);
            chk("s_blank", s_blank, e.bl);            chk("s_hsync_d", s_hsync_d, e.hsd);
            chk("s_vsync_d", s_vsync_d, e.vsd);       chk("s_blank_d", s_blank_d, e.bld);
            chk("s_line_start", s_line_start, e.ls);  chk("s_frame_start", s_frame_start, e.fs);
            chk("s_frame_count", s_frame_count, e.fc);
            e = model(t, 1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0, 0, 8);
            chk("x_hcount", x_hcount, e.h);           chk("x_vcount", x_vcount, e.v);
            chk("x_hsync", x_hsync, e.hs);            chk("x_vsync", x_vsync, e.vs);
            chk("x_blank", x_blank, e.bl);            chk("x_hsync_d", x_hsync_d, e.hsd);
            chk("x_vsync_d", x_vsync_d, e.vsd);       chk("x_blank_d", x_blank_d, e.bld);
            chk("x_line_start", x_line_start, e.ls);  chk("x_frame_start", x_frame_start, e.fs);
            chk("x_frame_count", x_frame_count, e.fc);
            // Hand-derived XGA edges that pin the model.
            if (x_vcount < 10'd768) begin
                if (x_hcount == 11'd1023) chk("x_blank_at_1023", x_blank, 0);
                if (x_hcount == 11'd1024) chk("x_blank_at_1024", x_blank, 1);
                if (x_hcount == 11'd1047) chk("x_hsync_at_1047", x_hsync, 1);
                if (x_hcount == 11'd1048) chk("x_hsync_at_1048", x_hsync, 0);
                if (x_hcount == 11'd1183) chk("x_hsync_at_1183", x_hsync, 0);
                if (x_hcount == 11'd1184) chk("x_hsync_at_1184", x_hsync, 1);
            end
        end
    end

    task automatic step(input bit r, input bit c);
        reset = r;
        ce    = c;
        @(posedge vclock);
        if (r) t = 0;
        else if (c) t = t + 1;
        @(negedge vclock);
    endtask

    initial begin
        int     last_fs;
        int     n_fs;
        int     n_seq;
        bit     found;
        int     exp_seq [5] = '{1, 2, 3, 0, 1};

        @(negedge vclock);
        step(1'b1, 1'b1);
        chk_en = 1'b1;
        chk("rst_hcount", s_hcount, 0);           chk("rst_vcount", s_vcount, 0);
        chk("rst_blank", s_blank, 0);             chk("rst_hsync", s_hsync, 0);
        chk("rst_vsync", s_vsync, 1);             chk("rst_line_start", s_line_start, 1);
        chk("rst_frame_start", s_frame_start, 1); chk("rst_frame_count", s_frame_count, 0);
        chk("rst_blank_d", s_blank_d, 1);         chk("rst_hsync_d", s_hsync_d, 0);
        chk("rst_x_blank_d", x_blank_d, 0);       chk("rst_x_hsync", x_hsync, 1);

        // Free run: frame_start must repeat every 25*11 = 275 ce-cycles.
        last_fs = 0;
        n_fs    = 0;
        for (int i = 1; i <= 560; i++) begin
            step(1'b0, 1'b1);
            if (s_frame_start) begin
                chk("frame_period", i - last_fs, 275);
                last_fs = i;
                n_fs++;
            end
        end
        chk("frames_seen", n_fs, 2);

        // Gated enable: strict toggling, then random.
        for (int i = 0; i < 1500; i++)
            step(1'b0, (i < 300) ? bit'(i % 2 == 0) : bit'($urandom_range(0, 3) != 0));

        // Mid-frame reset while hsync is active.
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            if (s_hcount == 5'd18 && s_vcount == 4'd3) found = 1'b1;
            else step(1'b0, bit'($urandom_range(0, 1)));
        end
        chk("midframe_found", found, 1);
        chk("mid_hsync_active", s_hsync, 1);
        step(1'b1, bit'($urandom_range(0, 1)));
        chk("mid_rst_hcount", s_hcount, 0);       chk("mid_rst_vcount", s_vcount, 0);
        chk("mid_rst_hsync", s_hsync, 0);         chk("mid_rst_blank", s_blank, 0);
        chk("mid_rst_frame_start", s_frame_start, 1);
        chk("mid_rst_frame_count", s_frame_count, 0);

        // Five frames with a 2-bit frame counter.
        n_seq = 0;
        for (int i = 1; i <= 5 * 275 + 10; i++) begin
            step(1'b0, 1'b1);
            if (s_frame_start && n_seq < 5) begin
                chk("frame_seq", s_frame_count, exp_seq[n_seq]);
                n_seq++;
            end
        end
        chk("frame_seq_len", n_seq, 5);

        // Reset held with ce low, then a short random tail.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 200; i++) step(1'b0, bit'($urandom_range(0, 1)));

        chk_en = 1'b0;
        @(posedge vclock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
